// File: rtl/rv32imf_instr_bus_arbiter.sv
// Two-port round-robin arbiter for the OBI instruction-memory port.
// Address phase is locked until granted; responses are routed back in order via an ID FIFO.
module rv32imf_instr_bus_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        s0_req_i,
    input  logic [31:0] s0_addr_i,
    output logic        s0_gnt_o,
    output logic        s0_rvalid_o,

    input  logic        s1_req_i,
    input  logic [31:0] s1_addr_i,
    output logic        s1_gnt_o,
    output logic        s1_rvalid_o,

    output logic [31:0] rdata_o,
    output logic        err_o,

    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,

    output logic        busy_o,
    output logic        protocol_err_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    logic             fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             lock_valid_q, lock_valid_d;
    logic             lock_id_q, lock_id_d;
    logic             rr_prio_q, rr_prio_d;
    logic             perr_q, perr_d;

    logic sel;
    logic sel_req;
    logic full;
    logic push;
    logic pop;
    logic head_id;
    logic stray_rvalid;
    logic lock_drop;

    // A held lock overrides round-robin so the presented address cannot change before its grant.
    always_comb begin
        sel     = 1'b0;
        sel_req = 1'b0;
        if (lock_valid_q) begin
            sel     = lock_id_q;
            sel_req = lock_id_q ? s1_req_i : s0_req_i;
        end else if (s0_req_i && s1_req_i) begin
            sel     = rr_prio_q;
            sel_req = 1'b1;
        end else if (s1_req_i) begin
            sel     = 1'b1;
            sel_req = 1'b1;
        end else if (s0_req_i) begin
            sel_req = 1'b1;
        end
    end

    assign full         = (count_q == MAX_CNT);
    assign instr_req_o  = sel_req && !full;
    assign instr_addr_o = sel_req ? (sel ? s1_addr_i : s0_addr_i) : '0;
    assign push         = instr_req_o && instr_gnt_i;
    assign s0_gnt_o     = push && !sel;
    assign s1_gnt_o     = push && sel;

    assign head_id      = fifo_q[rd_ptr_q];
    assign pop          = instr_rvalid_i && (count_q != '0);
    assign stray_rvalid = instr_rvalid_i && (count_q == '0);
    assign lock_drop    = lock_valid_q && !sel_req;
    assign s0_rvalid_o  = pop && !head_id;
    assign s1_rvalid_o  = pop && head_id;
    assign rdata_o      = instr_rdata_i;
    assign err_o        = instr_err_i;

    assign busy_o         = (count_q != '0) || lock_valid_q;
    assign protocol_err_o = perr_q;

    // NOTE: every next-state signal defaults to its current value first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rr_prio_d = rr_prio_q;

        if (push) begin
            wr_ptr_d  = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            rr_prio_d = ~sel;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        lock_valid_d = instr_req_o && !instr_gnt_i;
        lock_id_d    = lock_valid_d ? sel : lock_id_q;
        perr_d       = perr_q || stray_rvalid || lock_drop;
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_id_q    <= 1'b0;
            rr_prio_q    <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            rr_prio_q    <= rr_prio_d;
            perr_q       <= perr_d;
        end
    end

    // NOTE: the ID storage is not reset; an entry is only read after being written, guarded by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_rv32imf_instr_bus_arbiter.sv
// Self-checking bench: directed vector table, hand-written lock/reset sequences,
// then random traffic compared against a queue-based reference model.
module tb_rv32imf_instr_bus_arbiter;

    localparam int MAX_OUT = 2;
    localparam int NV      = 19;
    localparam int NRAND   = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_req_i, s1_req_i;
    logic [31:0] s0_addr_i, s1_addr_i;
    logic        s0_gnt_o, s1_gnt_o, s0_rvalid_o, s1_rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] instr_rdata_i;
    logic        busy_o, protocol_err_o;

    int checks = 0;
    int errors = 0;

    rv32imf_instr_bus_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .s0_req_i       (s0_req_i),
        .s0_addr_i      (s0_addr_i),
        .s0_gnt_o       (s0_gnt_o),
        .s0_rvalid_o    (s0_rvalid_o),
        .s1_req_i       (s1_req_i),
        .s1_addr_i      (s1_addr_i),
        .s1_gnt_o       (s1_gnt_o),
        .s1_rvalid_o    (s1_rvalid_o),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0;
        logic [31:0] a0;
        logic        r1;
        logic [31:0] a1;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic [1:0]  eg;
        logic [1:0]  erv;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ebusy;
        logic        eperr;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic r0, input logic [31:0] a0, input logic r1,
                                input logic [31:0] a1, input logic g, input logic rv,
                                input logic [31:0] rd, input logic [1:0] eg, input logic [1:0] erv,
                                input logic ereq, input logic [31:0] eaddr, input logic ebusy,
                                input logic eperr);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1; v.g = g; v.rv = rv; v.rd = rd;
        v.eg = eg; v.erv = erv; v.ereq = ereq; v.eaddr = eaddr; v.ebusy = ebusy; v.eperr = eperr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                         input logic g, input logic rv, input logic [31:0] rd, input logic er);
        s0_req_i = r0; s0_addr_i = a0;
        s1_req_i = r1; s1_addr_i = a1;
        instr_gnt_i = g; instr_rvalid_i = rv;
        instr_rdata_i = rd; instr_err_i = er;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample mid-cycle, well away from the rising edge.
    task automatic expect_out(input string tag, input logic [1:0] eg, input logic [1:0] erv,
                              input logic ereq, input logic [31:0] eaddr, input logic ebusy,
                              input logic eperr);
        #2;
        check({tag, ".gnt"},    {30'd0, s1_gnt_o, s0_gnt_o},       {30'd0, eg});
        check({tag, ".rvalid"}, {30'd0, s1_rvalid_o, s0_rvalid_o}, {30'd0, erv});
        check({tag, ".req"},    {31'd0, instr_req_o},              {31'd0, ereq});
        check({tag, ".addr"},   instr_addr_o,                      eaddr);
        check({tag, ".busy"},   {31'd0, busy_o},                   {31'd0, ebusy});
        check({tag, ".perr"},   {31'd0, protocol_err_o},           {31'd0, eperr});
        check({tag, ".rdata"},  rdata_o,                           instr_rdata_i);
        check({tag, ".err"},    {31'd0, err_o},                    {31'd0, instr_err_i});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
        tick();
        rst = 1'b0;
        expect_out("reset", 2'b00, 2'b00, 0, 32'h0, 0, 0);
    endtask

    // Random-phase reference model state
    int          q [$];
    int          lock_m;
    int          prio_m;
    bit          perr_m;
    bit          pend [2];
    logic [31:0] paddr [2];

    initial begin
        vecs[0]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,  2'b00, 2'b00, 0, 32'h0,   0, 0);
        vecs[1]  = mk(1, 32'h80,  0, 32'h0,   1, 0, 32'h0,  2'b01, 2'b00, 1, 32'h80,  0, 0);
        vecs[2]  = mk(0, 32'h0,   0, 32'h0,   0, 1, 32'h13, 2'b00, 2'b01, 0, 32'h0,   1, 0);
        vecs[3]  = mk(1, 32'h100, 1, 32'h200, 1, 0, 32'h0,  2'b10, 2'b00, 1, 32'h200, 0, 0);
        vecs[4]  = mk(1, 32'h104, 1, 32'h204, 1, 1, 32'hA1, 2'b01, 2'b10, 1, 32'h104, 1, 0);
        vecs[5]  = mk(1, 32'h108, 1, 32'h208, 1, 1, 32'hA2, 2'b10, 2'b01, 1, 32'h208, 1, 0);
        vecs[6]  = mk(1, 32'h10c, 1, 32'h20c, 1, 1, 32'hA3, 2'b01, 2'b10, 1, 32'h10c, 1, 0);
        vecs[7]  = mk(0, 32'h0,   0, 32'h0,   0, 1, 32'hA4, 2'b00, 2'b01, 0, 32'h0,   1, 0);
        vecs[8]  = mk(1, 32'h300, 0, 32'h0,   1, 0, 32'h0,  2'b01, 2'b00, 1, 32'h300, 0, 0);
        vecs[9]  = mk(0, 32'h0,   1, 32'h400, 1, 0, 32'h0,  2'b10, 2'b00, 1, 32'h400, 1, 0);
        vecs[10] = mk(1, 32'h304, 0, 32'h0,   1, 0, 32'h0,  2'b00, 2'b00, 0, 32'h304, 1, 0);
        vecs[11] = mk(1, 32'h304, 0, 32'h0,   1, 1, 32'hAA, 2'b00, 2'b01, 0, 32'h304, 1, 0);
        vecs[12] = mk(1, 32'h304, 0, 32'h0,   1, 0, 32'h0,  2'b01, 2'b00, 1, 32'h304, 1, 0);
        vecs[13] = mk(0, 32'h0,   0, 32'h0,   0, 1, 32'hB1, 2'b00, 2'b10, 0, 32'h0,   1, 0);
        vecs[14] = mk(0, 32'h0,   0, 32'h0,   0, 1, 32'hB2, 2'b00, 2'b01, 0, 32'h0,   1, 0);
        vecs[15] = mk(0, 32'h0,   0, 32'h0,   0, 1, 32'hB3, 2'b00, 2'b00, 0, 32'h0,   0, 0);
        vecs[16] = mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,  2'b00, 2'b00, 0, 32'h0,   0, 1);
        vecs[17] = mk(0, 32'h0,   1, 32'h500, 1, 0, 32'h0,  2'b10, 2'b00, 1, 32'h500, 0, 1);
        vecs[18] = mk(0, 32'h0,   0, 32'h0,   0, 1, 32'hC1, 2'b00, 2'b10, 0, 32'h0,   1, 1);

        do_reset();
        tick();
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1, vecs[i].g, vecs[i].rv, vecs[i].rd, 0);
            expect_out($sformatf("vec%0d", i), vecs[i].eg, vecs[i].erv, vecs[i].ereq,
                       vecs[i].eaddr, vecs[i].ebusy, vecs[i].eperr);
            tick();
        end

        // Lock: s1 held off by gnt=0 keeps the bus even when s0 joins
        do_reset();
        tick();
        drive(0, 32'h0,   1, 32'h600, 0, 0, 32'h0, 0);
        expect_out("lock0", 2'b00, 2'b00, 1, 32'h600, 0, 0); tick();
        drive(1, 32'h700, 1, 32'h600, 0, 0, 32'h0, 0);
        expect_out("lock1", 2'b00, 2'b00, 1, 32'h600, 1, 0); tick();
        drive(1, 32'h700, 1, 32'h600, 0, 0, 32'h0, 0);
        expect_out("lock2", 2'b00, 2'b00, 1, 32'h600, 1, 0); tick();
        drive(1, 32'h700, 1, 32'h600, 1, 0, 32'h0, 0);
        expect_out("lock3", 2'b10, 2'b00, 1, 32'h600, 1, 0); tick();
        drive(1, 32'h700, 0, 32'h0,   1, 0, 32'h0, 0);
        expect_out("lock4", 2'b01, 2'b00, 1, 32'h700, 1, 0); tick();
        drive(0, 32'h0,   0, 32'h0,   0, 1, 32'h11, 0);
        expect_out("lock5", 2'b00, 2'b10, 0, 32'h0,   1, 0); tick();
        drive(0, 32'h0,   0, 32'h0,   0, 1, 32'h22, 1);
        expect_out("lock6", 2'b00, 2'b01, 0, 32'h0,   1, 0); tick();

        // Locked port drops its request: violation, arbitration resumes
        drive(1, 32'h800, 0, 32'h0,   0, 0, 32'h0, 0);
        expect_out("drop0", 2'b00, 2'b00, 1, 32'h800, 0, 0); tick();
        drive(0, 32'h0,   1, 32'h900, 0, 0, 32'h0, 0);
        expect_out("drop1", 2'b00, 2'b00, 0, 32'h0,   1, 0); tick();
        drive(0, 32'h0,   1, 32'h900, 1, 0, 32'h0, 0);
        expect_out("drop2", 2'b10, 2'b00, 1, 32'h900, 0, 1); tick();
        drive(1, 32'hA00, 0, 32'h0,   1, 1, 32'h33, 0);
        expect_out("drop3", 2'b01, 2'b10, 1, 32'hA00, 1, 1); tick();
        drive(1, 32'hA04, 1, 32'hB00, 1, 0, 32'h0, 0);
        expect_out("drop4", 2'b10, 2'b00, 1, 32'hB00, 1, 1); tick();

        // Reset with two outstanding; a late rvalid is a violation
        do_reset();
        tick();
        drive(0, 32'h0, 0, 32'h0, 0, 1, 32'h44, 0);
        expect_out("late0", 2'b00, 2'b00, 0, 32'h0, 0, 0); tick();
        drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
        expect_out("late1", 2'b00, 2'b00, 0, 32'h0, 0, 1); tick();

        // Random traffic against the queue-based model
        do_reset();
        tick();
        q.delete();
        lock_m = -1;
        prio_m = 0;
        perr_m = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        paddr[0] = 32'h0;
        paddr[1] = 32'h0;
        for (int c = 0; c < NRAND; c++) begin
            int          sel;
            bit          sreq, g, rv, fire;
            logic [1:0]  eg, erv;
            logic        ereq, ebusy;
            logic [31:0] eaddr;
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && ($urandom_range(0, 99) < 50)) begin
                    pend[n]  = 1'b1;
                    paddr[n] = $urandom() & 32'hFFFF_FFFC;
                end
            end
            g  = ($urandom_range(0, 99) < 60);
            rv = (q.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 2);
            drive(pend[0], paddr[0], pend[1], paddr[1], g, rv, $urandom(), 1'($urandom_range(0, 1)));

            if (lock_m >= 0) begin
                sel = lock_m; sreq = pend[lock_m];
            end else if (pend[0] && pend[1]) begin
                sel = prio_m; sreq = 1'b1;
            end else if (pend[1]) begin
                sel = 1; sreq = 1'b1;
            end else begin
                sel = 0; sreq = pend[0];
            end
            ereq  = sreq && (q.size() < MAX_OUT);
            eaddr = sreq ? paddr[sel] : 32'h0;
            fire  = ereq && g;
            eg    = fire ? ((sel == 1) ? 2'b10 : 2'b01) : 2'b00;
            erv   = (rv && q.size() > 0) ? ((q[0] == 1) ? 2'b10 : 2'b01) : 2'b00;
            ebusy = (q.size() > 0) || (lock_m >= 0);
            expect_out($sformatf("rnd%0d", c), eg, erv, ereq, eaddr, ebusy, perr_m);

            if (rv && q.size() == 0) perr_m = 1'b1;
            if (lock_m >= 0 && !pend[lock_m]) perr_m = 1'b1;
            if (rv && q.size() > 0) void'(q.pop_front());
            if (fire) begin
                q.push_back(sel);
                prio_m    = 1 - sel;
                pend[sel] = 1'b0;
            end
            lock_m = (ereq && !g) ? sel : -1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
